key_input: RTL

KEY_INPUT -- requirements
Module: key_input

---
 rtl/key_input_if.sv | 11 +
 rtl/key_input.sv | 100 ++++++++++
 2 files changed

// File: rtl/key_input_if.sv
// Register bus for key_input: write strobe, word address, write data, read data and interrupt.
interface key_input_if;
    logic        WE;
    logic [1:0]  Addr;
    logic [3:0]  Din;
    logic [31:0] Dout;
    logic        irq;

    modport master (output WE, Addr, Din, input Dout, irq);
    modport slave  (input WE, Addr, Din, output Dout, irq);
endinterface

// File: rtl/key_input.sv
// Four-key debouncer with LEVEL/EVENT/MASK registers and a level interrupt.
// Define KEY_INPUT_IRQ_EN to include the MASK register and a live irq; otherwise irq is tied low.
module key_input #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_n,
    key_input_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       level;
    logic [3:0]       event_q;
    logic [3:0]       mask;
    logic [CNT_W-1:0] cnt [4];

    logic [3:0] pressed;
    logic [3:0] accept;
    logic [3:0] press_set;
    logic [3:0] w1c;

    always_comb begin
        pressed   = ~sync2;
        accept    = '0;
        for (int i = 0; i < 4; i++) begin
            accept[i] = (pressed[i] != level[i]) && (cnt[i] == CNT_LAST);
        end
        press_set = accept & pressed;
        w1c       = (bus.WE && bus.Addr == 2'd1) ? bus.Din : 4'd0;
    end

    // Synchronizer resets to the released level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 4'hF;
            sync2 <= 4'hF;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (pressed[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] < CNT_LAST) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end else begin
                    level[i] <= pressed[i];
                    cnt[i]   <= '0;
                end
            end
        end
    end

    // A press on the same edge as a write-1-to-clear keeps the bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            event_q <= '0;
        end else begin
            event_q <= (event_q & ~w1c) | press_set;
        end
    end

`ifdef KEY_INPUT_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= '0;
        end else if (bus.WE && bus.Addr == 2'd2) begin
            mask <= bus.Din;
        end
    end
`else
    assign mask = '0;
`endif

    always_comb begin
        case (bus.Addr)
            2'd0:    bus.Dout = {28'd0, level};
            2'd1:    bus.Dout = {28'd0, event_q};
            2'd2:    bus.Dout = {28'd0, mask};
            default: bus.Dout = 32'd0;
        endcase
    end

    assign bus.irq = |(event_q & mask);

endmodule
